// File: rtl/amp_det_pkg.sv
// Shared definitions for the amplitude detector: default sizes, derived
// widths, controller state encoding and output reset values.
package amp_det_pkg;

    // Default sample width and log2 of the averaging window length.
    localparam int DATA_W_DEF   = 16;
    localparam int WIN_LOG2_DEF = 6;

    // Magnitude loses the sign bit; the accumulator grows by WIN_LOG2 bits
    // so a full window of maximum magnitudes cannot overflow.
    localparam int MAG_W = DATA_W_DEF - 1;
    localparam int ACC_W = MAG_W + WIN_LOG2_DEF;

    // Controller: IDLE while the detector is disabled, RUN while enabled.
    typedef enum logic {
        DET_IDLE = 1'b0,
        DET_RUN  = 1'b1
    } det_state_t;

    // Values the decision outputs take after reset.
    localparam logic        IS_LARGE_RST = 1'b0;
    localparam int unsigned LEVEL_RST    = 0;

endpackage

// File: rtl/amp_detector_abs_sat.sv
// Stage 1: registered saturating absolute value of a signed sample.
// The most negative input maps to the largest positive magnitude.
module amp_detector_abs_sat
    import amp_det_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              abs_v,
    output logic [DATA_W-2:0] abs_d
);

    localparam int MAG_BITS = DATA_W - 1;

    logic [DATA_W-1:0]   neg_data;
    logic [MAG_BITS-1:0] mag_c;

    // Combinational rectify with saturation of the most negative code.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        mag_c    = s_data[MAG_BITS-1:0];
        neg_data = -s_data;
        if (s_data == {1'b1, {MAG_BITS{1'b0}}}) begin
            mag_c = {MAG_BITS{1'b1}};
        end else if (s_data[DATA_W-1]) begin
            mag_c = neg_data[MAG_BITS-1:0];
        end
    end

    // Qualifier register: cleared by reset and whenever the stage is disabled.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            abs_v <= 1'b0;
        end else begin
            abs_v <= s_valid & en;
        end
    end

    // Magnitude register: pure datapath, only meaningful when abs_v is high.
    always_ff @(posedge clk) begin
        // NOTE: the data register is not reset; its qualifier abs_v is, and
        // nothing downstream uses abs_d without abs_v.
        abs_d <= mag_c;
    end

endmodule

// File: rtl/amp_detector.sv
// Amplitude detector: rectifies samples, averages magnitudes over windows of
// 2^WIN_LOG2 accepted samples and applies a threshold with hysteresis.
// One-cycle in_en strobe per completed window qualifies is_large / level.
module amp_detector
    import amp_det_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              det_en,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic [DATA_W-2:0] thr_hi,
    input  logic [DATA_W-2:0] thr_lo,
    output logic              is_large,
    output logic              in_en,
    output logic [DATA_W-2:0] level
);

    localparam int MAG_BITS = DATA_W - 1;
    localparam int ACC_BITS = MAG_BITS + WIN_LOG2;

    det_state_t state_q;
    det_state_t state_d;
    logic       clr;

    logic                abs_v;
    logic [MAG_BITS-1:0] abs_d;

    logic [ACC_BITS-1:0] acc;
    logic [WIN_LOG2-1:0] cnt;
    logic [ACC_BITS-1:0] sum;
    logic [MAG_BITS-1:0] mean;
    logic                take;
    logic                last;

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DET_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Controller next state; window state is cleared whenever heading to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DET_IDLE: if (det_en)  state_d = DET_RUN;
            DET_RUN:  if (!det_en) state_d = DET_IDLE;
            default:  state_d = DET_IDLE;
        endcase
        clr = (state_d == DET_IDLE);
    end

    amp_detector_abs_sat #(
        .DATA_W (DATA_W)
    ) u_abs_sat (
        .clk     (clk),
        .rst     (rst),
        .en      (~clr),
        .s_valid (s_valid),
        .s_data  (s_data),
        .abs_v   (abs_v),
        .abs_d   (abs_d)
    );

    // Window arithmetic: a sample staged in stage 1 is dropped if the
    // detector is disabled on the edge that would have consumed it.
    always_comb begin
        take = abs_v & ~clr;
        last = take & (&cnt);
        sum  = acc + {{WIN_LOG2{1'b0}}, abs_d};
        mean = sum[ACC_BITS-1:WIN_LOG2];
    end

    // Accumulator and sample counter; counter wraps to zero at window end.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (take) begin
            acc <= last ? '0 : sum;
            cnt <= cnt + 1'b1;
        end
    end

    // Window-end outputs: strobe, held mean and hysteresis decision.
    // The set test comes first so it wins when thr_lo > thr_hi.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_en    <= 1'b0;
            level    <= MAG_BITS'(LEVEL_RST);
            is_large <= IS_LARGE_RST;
        end else begin
            in_en <= last;
            if (last) begin
                level <= mean;
                if (mean >= thr_hi) begin
                    is_large <= 1'b1;
                end else if (mean < thr_lo) begin
                    is_large <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_amp_detector.sv
// Self-checking bench for amp_detector with a window of 4 samples.
// A queue-based window model predicts the outputs; a compare process checks
// them every cycle, and directed scenarios pin literal expectations.
module tb_amp_detector;

    localparam int DW  = 16;
    localparam int WL2 = 2;
    localparam int WIN = 1 << WL2;

    logic          clk = 1'b0;
    logic          rst;
    logic          det_en;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic [DW-2:0] thr_hi;
    logic [DW-2:0] thr_lo;
    logic          is_large;
    logic          in_en;
    logic [DW-2:0] level;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Model state.
    int   win[$];
    bit   pend_v     = 1'b0;
    int   pend_m     = 0;
    bit   exp_in_en  = 1'b0;
    bit   exp_large  = 1'b0;
    int   exp_level  = 0;
    bit   model_live = 1'b0;

    amp_detector #(
        .DATA_W   (DW),
        .WIN_LOG2 (WL2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .det_en   (det_en),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .thr_hi   (thr_hi),
        .thr_lo   (thr_lo),
        .is_large (is_large),
        .in_en    (in_en),
        .level    (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Saturating magnitude of a signed sample, in plain integer arithmetic.
    function automatic int mag(input logic [DW-1:0] d);
        int v;
        v = int'($signed(d));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    // Model: a sample accepted on one edge joins the window on the next edge
    // if the detector is still enabled; a full window yields mean and decision.
    always @(posedge clk) begin
        int sum;
        int mean;
        if (rst) begin
            win.delete();
            pend_v     = 1'b0;
            exp_in_en  = 1'b0;
            exp_large  = 1'b0;
            exp_level  = 0;
            model_live = 1'b1;
        end else begin
            exp_in_en = 1'b0;
            if (!det_en) begin
                win.delete();
                pend_v = 1'b0;
            end else begin
                if (pend_v) begin
                    win.push_back(pend_m);
                    if (win.size() == WIN) begin
                        sum = 0;
                        foreach (win[i]) sum += win[i];
                        mean      = sum / WIN;
                        exp_level = mean;
                        exp_in_en = 1'b1;
                        if (mean >= int'(thr_hi))     exp_large = 1'b1;
                        else if (mean < int'(thr_lo)) exp_large = 1'b0;
                        win.delete();
                    end
                end
                pend_v = s_valid;
                pend_m = mag(s_data);
            end
        end
    end

    // Compare process: checks every output on every cycle, away from the edge.
    always @(negedge clk) begin
        if (model_live) begin
            check("in_en", int'(in_en), int'(exp_in_en));
            check("is_large", int'(is_large), int'(exp_large));
            check("level", int'(level), exp_level);
            if (in_en) pulses++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d);
        s_valid = 1'b1;
        s_data  = DW'(d);
        step();
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send4(input int d);
        for (int i = 0; i < WIN; i++) send(d);
    endtask

    initial begin
        int base;
        rst     = 1'b1;
        det_en  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        thr_hi  = 15'd50;
        thr_lo  = 15'd30;
        idle(2);
        check("reset in_en", int'(in_en), 0);
        check("reset is_large", int'(is_large), 0);
        check("reset level", int'(level), 0);
        rst    = 1'b0;
        det_en = 1'b1;
        idle(1);

        // Four samples of +100: one strobe, level 100, set.
        base = pulses;
        send4(100);
        check("lat T+1 no strobe", int'(in_en), 0);
        step();
        check("lat T+2 strobe", int'(in_en), 1);
        idle(2);
        check("w100 pulses", pulses - base, 1);
        check("w100 level", int'(level), 100);
        check("w100 is_large", int'(is_large), 1);

        // -40: mean between thresholds, decision holds.
        send4(-40);
        idle(3);
        check("w40 level", int'(level), 40);
        check("w40 is_large held", int'(is_large), 1);

        // 20: below clear threshold.
        send4(20);
        idle(3);
        check("w20 level", int'(level), 20);
        check("w20 is_large", int'(is_large), 0);

        // Most negative sample saturates; no overflow.
        send(-32768); send(0); send(0); send(0);
        idle(3);
        check("wmin level", int'(level), 8191);

        // Gapped window: gaps of 0, 3 and 5 idle cycles.
        base = pulses;
        send(3); send(3); idle(3); send(3); idle(5); send(4);
        idle(3);
        check("gap pulses", pulses - base, 1);
        check("gap level", int'(level), 3);
        check("gap is_large", int'(is_large), 0);

        // Disable while the last sample sits in stage 1: window dropped.
        base = pulses;
        send(5); send(5); send(5); send(5);
        det_en = 1'b0;
        idle(2);
        det_en = 1'b1;
        idle(3);
        check("drop pulses", pulses - base, 0);
        check("drop level held", int'(level), 3);

        // Partial window, detector disabled 3 cycles, then a full window.
        base = pulses;
        send(7); send(7);
        det_en = 1'b0;
        idle(3);
        det_en = 1'b1;
        send4(10);
        idle(3);
        check("den pulses", pulses - base, 1);
        check("den level", int'(level), 10);

        // Set the decision, then partial window aborted by reset.
        send4(100);
        idle(3);
        check("pre-rst is_large", int'(is_large), 1);
        base = pulses;
        send(7); send(7);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        check("rst is_large", int'(is_large), 0);
        check("rst level", int'(level), 0);
        send4(10);
        idle(3);
        check("rst pulses", pulses - base, 1);
        check("rst win level", int'(level), 10);

        // Inverted thresholds with mean between them: set wins.
        thr_lo = 15'd80;
        thr_hi = 15'd60;
        send4(70);
        idle(3);
        check("inv level", int'(level), 70);
        check("inv is_large", int'(is_large), 1);

        // Back-to-back windows: two strobes in 8 samples, never adjacent.
        thr_hi = 15'd50;
        thr_lo = 15'd30;
        base = pulses;
        send4(1);
        send4(200);
        idle(3);
        check("b2b pulses", pulses - base, 2);
        check("b2b level", int'(level), 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/amp_detector.md
# amp_detector

Front-end amplitude detector that turns the raw microphone sample stream into the per-window `is_large` / `in_en` pair consumed by the mosquito counter. It rectifies each sample, averages magnitudes over fixed windows of 2^WIN_LOG2 accepted samples, and applies a runtime-programmable threshold with hysteresis. Once per completed window it issues a one-cycle `in_en` strobe qualifying the updated `is_large` level.

## Interface
- `DATA_W`, 16: sample width, signed two's complement.
- `WIN_LOG2`, 6: log2 of samples per window, legal range 1..10.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `det_en`  in  1  detector enable; low clears window state.
- `s_valid`  in  1  sample qualifier; no backpressure, every valid sample is accepted.
- `s_data`  in  DATA_W  signed sample.
- `thr_hi`  in  DATA_W-1  set threshold on window mean magnitude.
- `thr_lo`  in  DATA_W-1  clear threshold on window mean magnitude.
- `is_large`  out  1  registered hysteresis decision, held between windows.
- `in_en`  out  1  one-cycle strobe, high once per completed window.
- `level`  out  DATA_W-1  mean magnitude of the last completed window, held.

## Operation
- Stage 1, rectify: `abs_v <= s_valid & det_en`; `abs_d <= |s_data|`. -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1. Result is unsigned, DATA_W-1 bits.
- Stage 2, accumulate: `acc` is DATA_W-1+WIN_LOG2 bits and cannot overflow. `cnt` is WIN_LOG2 bits and counts accepted samples in the window.
  - On `abs_v` with `cnt` not equal to all-ones: `acc += abs_d`, `cnt += 1`.
  - On `abs_v` with `cnt` equal to all-ones (last sample): window ends.
    - `mean = (acc + abs_d) >> WIN_LOG2`, truncating.
    - `level <= mean`; `in_en <= 1`.
    - `acc <= 0`; `cnt` wraps to 0.
  - `in_en` is 0 in every cycle without a window end.
- Hysteresis, evaluated only at window end, thresholds sampled on that same edge:
  - `mean >= thr_hi` → `is_large <= 1`.
  - else `mean < thr_lo` → `is_large <= 0`.
  - else hold.
  - If `thr_lo > thr_hi` and both conditions hold, set wins.
- Two-state controller: IDLE (`det_en` = 0) and RUN.
  - IDLE→RUN when `det_en` = 1.
  - RUN→IDLE when `det_en` = 0.
  - Entering IDLE clears `acc`, `cnt`, `abs_v`; a partial window is discarded with no strobe.
  - `is_large` and `level` keep their last values in IDLE.
- Reset: `is_large`=0, `in_en`=0, `level`=0, `acc`=0, `cnt`=0, `abs_v`=0, state IDLE. Reset mid-window discards the partial window.

## Timing
- Latency: the last sample of a window is presented in cycle T with `s_valid`=1. `in_en`, `is_large` and `level` update at the edge ending T+1 and are visible in cycle T+2. `in_en` is high for exactly that cycle.
- Back-to-back `s_valid` is supported at one sample per clock. Window period is then exactly 2^WIN_LOG2 cycles, and `in_en` never asserts on consecutive cycles when WIN_LOG2 ≥ 1.
- Gaps in `s_valid` stretch the window; nothing times out.
- `det_en` falling while a last sample sits in stage 1 (`abs_v`=1): that window is dropped, no `in_en`.
- `rst` has priority over every other input on the same edge.

## Structure
- Package `amp_det_pkg` holds:
  - DATA_W / WIN_LOG2 defaults.
  - Derived widths `MAG_W = DATA_W-1`, `ACC_W = MAG_W+WIN_LOG2`.
  - State enum `{DET_IDLE, DET_RUN}`.
  - Reset constants for `level` and `is_large`.
- Sub-module `abs_sat`: registered saturating absolute value (stage 1). The top level instantiates it plus the accumulator, controller and hysteresis logic.

## Test plan
All scenarios use WIN_LOG2=2, DATA_W=16.
- Reset, then 4 back-to-back samples of +100 with thr_hi=50, thr_lo=30 → single `in_en` pulse 2 cycles after the 4th sample, `level`=100, `is_large`=1.
- Then 4 samples of -40 → `level`=40, `is_large` stays 1 (hysteresis). Then 4 samples of 20 → `level`=20, `is_large`=0.
- Samples {-32768, 0, 0, 0} → `level`=8191 (32767>>2), no overflow.
- Samples {3, 3, 3, 4} with `s_valid` gaps of 0–5 idle cycles → exactly one `in_en`, `level`=3 (13>>2); no `in_en` during the gaps.
- Boundary cases:
  - 2 samples, then `det_en` low for 3 cycles, then 4 samples of 10 → exactly one `in_en`, `level`=10.
  - Same sequence with `rst` pulsed instead of `det_en` → same single strobe, `is_large` reset to 0 before it.
- thr_lo=80, thr_hi=60, window mean=70 → `is_large`=1 (set priority).
